branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Fetch-side partner of the execute stage's branch resolution.
- Supplies the predicted next_pc for each fetched PC from a direct-mapped branch target buffer with 2-bit saturating counters.
- Is trained by the resolution packet (pc, taken, resolved next_pc, mispredict flag) that execute produces for br/jal/jalr.
- Keeps saturating lookup and mispredict performance counters.

Parameters:
- ENTRIES, 32, number of BTB entries; power of 2, range 4..256.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- fetch_pc  in  32  PC being fetched this cycle.
- fetch_valid  in  1  fetch_pc is a real lookup; gates the lookup counter.
- pred_next_pc  out  32  predicted next PC for fetch_pc (combinational).
- pred_taken  out  1  prediction is a BTB redirect.
- upd_valid  in  1  execute resolved a valid control-flow instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_is_jump  in  1  instruction is jal/jalr (unconditional).
- upd_taken  in  1  branch taken (forced 1 when upd_is_jump).
- upd_target  in  32  resolved next_pc from execute.
- upd_mispredict  in  1  inverse of execute's correct_pc_prediction.
- flush_table  in  1  invalidate all entries.
- perf_lookups  out  32  count of fetch_valid cycles.
- perf_mispredicts  out  32  count of upd_valid && upd_mispredict.

Behaviour:
- Table entry: valid(1), tag(30-IDX_W), target(32), ctr(2).
- Entry index: pc[IDX_W+1:2]. Tag: pc[31:IDX_W+2].
- Lookup is combinational from table flops.
  - hit = entry valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_next_pc = pred_taken ? target : fetch_pc + 32'd4, wrapping mod 2^32.
- Update is applied at the rising edge when upd_valid=1. Effective taken = upd_taken | upd_is_jump.
  - Hit and taken: target <= upd_target. Jump: ctr <= 2'b11. Branch: ctr <= sat_inc(ctr).
  - Hit and not taken: ctr <= sat_dec(ctr); target unchanged.
  - Miss and taken: allocate, overwriting any valid entry. valid <= 1, tag <= upd tag, target <= upd_target, ctr <= 2'b11 for a jump, else 2'b10.
  - Miss and not taken: no change.
- Saturation: ctr never wraps; 11 stays 11 on inc, 00 stays 00 on dec.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; no bypass. The new value is visible the next cycle.
- flush_table=1: all valid <= 0 at the edge. Flush has priority over a simultaneous update, so that update is dropped. Perf counters are unaffected.
- Perf counters increment by 1 per qualifying cycle and saturate at 32'hFFFF_FFFF.
- Reset (rst=0 at an edge): all valid <= 0, ctr <= 2'b01, target <= 0, tag <= 0, perf counters <= 0.
  - From the next cycle, every lookup misses, so pred_taken=0 and pred_next_pc=fetch_pc+4.
  - Reset overrides update and flush in the same cycle.
  - Reset mid-stream leaves no partial entry.
- Outputs with no update have no further state machine; latency is 0 cycles for prediction and 1 cycle for training visibility.
- upd_valid=0: inputs ignored regardless of other upd_* values; X on ignored inputs must not propagate.

Test Plan:
- Reset then lookup 0x0000_0060 -> pred_taken=0, pred_next_pc=0x0000_0064; perf_lookups=1 after the cycle.
- Update pc=0x0000_0100, branch taken, target=0x0000_0080 -> next-cycle lookup of 0x100 gives pred_taken=1, pred_next_pc=0x80 (ctr=10). Two not-taken updates -> ctr 00, prediction 0x104. Three taken updates -> ctr saturates at 11.
- Aliasing with ENTRIES=32: train jal pc=0x100 -> 0x200, then jal pc=0x180 (same index, different tag) -> 0x300. Lookup 0x100 misses (0x104); lookup 0x180 gives 0x300.
- Same-cycle update and lookup: lookup 0x100 while allocating 0x100 -> that cycle returns 0x104; next cycle returns the trained target.
- flush_table with a simultaneous taken update to 0x140 -> all lookups miss afterward, including 0x140. perf_mispredicts is preserved.
- Mid-run reset after 5 mispredict updates -> perf_mispredicts=0 and all entries miss. Preload perf_lookups near max via a long run/force at 0xFFFF_FFFE, then 3 lookups -> it holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Fetch-side branch target predictor: direct-mapped BTB with 2-bit saturating
// counters, trained by execute's resolution packet, plus saturating perf counters.
module branch_target_predictor #(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    output logic [31:0] pred_next_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        flush_table,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] lookups_q;
    logic [31:0] mispredicts_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_eff_taken;
    logic             unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Word-aligned PCs: the two low bits never take part in index or tag.
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    assign pred_taken   = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;

    assign upd_idx       = upd_pc[IDX_W+1:2];
    assign upd_tag       = upd_pc[31:IDX_W+2];
    assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_eff_taken = upd_taken | upd_is_jump;

    // No bypass: a same-cycle lookup sees the table as it was before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush_table) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_eff_taken) begin
                    target_q[upd_idx] <= upd_target;
                    ctr_q[upd_idx]    <= upd_is_jump ? 2'b11 : sat_inc(ctr_q[upd_idx]);
                end else begin
                    ctr_q[upd_idx] <= sat_dec(ctr_q[upd_idx]);
                end
            end else if (upd_eff_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (fetch_valid && (lookups_q != 32'hFFFF_FFFF)) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (upd_valid && upd_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_lookups     = lookups_q;
    assign perf_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor (ENTRIES=32).
module tb_branch_target_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush_table;
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;

    int n_checks;
    int n_pass;
    logic [31:0] exp_mis;

    branch_target_predictor #(.ENTRIES(32)) dut (
        .clk(clk), .rst(rst),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .pred_next_pc(pred_next_pc), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_table(flush_table),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_upd();
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b0;
        flush_table    = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic jump, input logic taken,
                           input logic [31:0] target, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = jump;
        upd_taken      = taken;
        upd_target     = target;
        upd_mispredict = mis;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc = 32'h0;
        clear_upd();
        step();
        step();
        rst = 1'b1;
        fetch_pc = 32'h0000_0060;
        fetch_valid = 1'b1;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h0000_0064)
            $display("FAIL reset_lookup: got taken=%0b next=%h, want taken=0 next=00000064", pred_taken, pred_next_pc);
        else n_pass++;
        n_checks++;
        if (perf_lookups !== 32'd0 || perf_mispredicts !== 32'd0)
            $display("FAIL reset_perf: got lookups=%h mis=%h, want 0/0", perf_lookups, perf_mispredicts);
        else n_pass++;
        step();
        fetch_valid = 1'b0;
        n_checks++;
        if (perf_lookups !== 32'd1)
            $display("FAIL lookup_count: got %h, want 00000001", perf_lookups);
        else n_pass++;
    endtask

    task automatic test_counter();
        logic nt_tk  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_tk [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        set_upd(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
        exp_mis = exp_mis + 1;
        step();
        clear_upd();
        fetch_pc = 32'h0000_0100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0080)
            $display("FAIL alloc_branch: got taken=%0b next=%h, want taken=1 next=00000080", pred_taken, pred_next_pc);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            set_upd(32'h0000_0100, 1'b0, nt_tk[i], 32'h0000_0080, 1'b0);
            step();
            clear_upd();
            fetch_pc = 32'h0000_0100;
            #1;
            n_checks++;
            if (pred_taken !== exp_tk[i] ||
                pred_next_pc !== (exp_tk[i] ? 32'h0000_0080 : 32'h0000_0104))
                $display("FAIL ctr_step%0d: got taken=%0b next=%h, want taken=%0b", i, pred_taken, pred_next_pc, exp_tk[i]);
            else n_pass++;
        end
    endtask

    task automatic test_alias();
        set_upd(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 1'b1);
        exp_mis = exp_mis + 1;
        step();
        clear_upd();
        fetch_pc = 32'h0000_0100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0200)
            $display("FAIL jal_hit: got taken=%0b next=%h, want taken=1 next=00000200", pred_taken, pred_next_pc);
        else n_pass++;
        set_upd(32'h0000_0180, 1'b1, 1'b0, 32'h0000_0300, 1'b0);
        step();
        clear_upd();
        fetch_pc = 32'h0000_0100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h0000_0104)
            $display("FAIL alias_evict: got taken=%0b next=%h, want taken=0 next=00000104", pred_taken, pred_next_pc);
        else n_pass++;
        fetch_pc = 32'h0000_0180;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0300)
            $display("FAIL alias_new: got taken=%0b next=%h, want taken=1 next=00000300", pred_taken, pred_next_pc);
        else n_pass++;
        // a jump allocates at 11, so one not-taken leaves it still predicting taken
        set_upd(32'h0000_0180, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        clear_upd();
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0300)
            $display("FAIL jal_ctr11: got taken=%0b next=%h, want taken=1 next=00000300", pred_taken, pred_next_pc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        fetch_pc = 32'h0000_0100;
        set_upd(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0500, 1'b0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h0000_0104)
            $display("FAIL same_cycle: got taken=%0b next=%h, want taken=0 next=00000104", pred_taken, pred_next_pc);
        else n_pass++;
        step();
        clear_upd();
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0500)
            $display("FAIL next_cycle: got taken=%0b next=%h, want taken=1 next=00000500", pred_taken, pred_next_pc);
        else n_pass++;
        // idle update port with not-taken payload must be ignored
        upd_valid = 1'b0;
        upd_pc = 32'h0000_0100;
        upd_taken = 1'b0;
        upd_is_jump = 1'bx;
        upd_target = 32'hxxxx_xxxx;
        upd_mispredict = 1'b1;
        step();
        step();
        clear_upd();
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_0500 || perf_mispredicts !== exp_mis)
            $display("FAIL upd_ignored: got taken=%0b next=%h mis=%h, want taken=1 next=00000500 mis=%h",
                     pred_taken, pred_next_pc, perf_mispredicts, exp_mis);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] pcs [3] = '{32'h0000_0100, 32'h0000_0140, 32'h0000_0180};
        flush_table = 1'b1;
        set_upd(32'h0000_0140, 1'b0, 1'b1, 32'h0000_0600, 1'b0);
        step();
        clear_upd();
        for (int i = 0; i < 3; i++) begin
            fetch_pc = pcs[i];
            #1;
            n_checks++;
            if (pred_taken !== 1'b0 || pred_next_pc !== pcs[i] + 32'd4)
                $display("FAIL flush_miss%0d: got taken=%0b next=%h, want taken=0 next=%h", i, pred_taken, pred_next_pc, pcs[i] + 32'd4);
            else n_pass++;
        end
        n_checks++;
        if (perf_mispredicts !== exp_mis)
            $display("FAIL flush_perf: got %h, want %h", perf_mispredicts, exp_mis);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h0000_0200 + 32'(4 * i), 1'b0, 1'b1, 32'h0000_1000 + 32'(i), 1'b1);
            step();
        end
        clear_upd();
        exp_mis = exp_mis + 5;
        fetch_pc = 32'h0000_0210;
        #1;
        n_checks++;
        if (perf_mispredicts !== exp_mis || pred_taken !== 1'b1 || pred_next_pc !== 32'h0000_1004)
            $display("FAIL pre_reset: got mis=%h taken=%0b next=%h, want mis=%h taken=1 next=00001004",
                     perf_mispredicts, pred_taken, pred_next_pc, exp_mis);
        else n_pass++;
        rst = 1'b0;
        set_upd(32'h0000_0214, 1'b0, 1'b1, 32'h0000_2000, 1'b1);
        step();
        rst = 1'b1;
        clear_upd();
        exp_mis = 32'd0;
        for (int i = 0; i < 6; i++) begin
            fetch_pc = 32'h0000_0200 + 32'(4 * i);
            #1;
            n_checks++;
            if (pred_taken !== 1'b0 || pred_next_pc !== fetch_pc + 32'd4)
                $display("FAIL reset_miss%0d: got taken=%0b next=%h, want taken=0 next=%h", i, pred_taken, pred_next_pc, fetch_pc + 32'd4);
            else n_pass++;
        end
        n_checks++;
        if (perf_mispredicts !== 32'd0 || perf_lookups !== 32'd0)
            $display("FAIL reset_perf_mid: got mis=%h lookups=%h, want 0/0", perf_mispredicts, perf_lookups);
        else n_pass++;
    endtask

    task automatic test_perf_sat();
        force dut.lookups_q = 32'hFFFF_FFFE;
        #1;
        release dut.lookups_q;
        #1;
        n_checks++;
        if (perf_lookups !== 32'hFFFF_FFFE)
            $display("FAIL perf_preload: got %h, want fffffffe", perf_lookups);
        else n_pass++;
        fetch_valid = 1'b1;
        step();
        n_checks++;
        if (perf_lookups !== 32'hFFFF_FFFF)
            $display("FAIL perf_reach_max: got %h, want ffffffff", perf_lookups);
        else n_pass++;
        step();
        step();
        fetch_valid = 1'b0;
        n_checks++;
        if (perf_lookups !== 32'hFFFF_FFFF)
            $display("FAIL perf_saturate: got %h, want ffffffff", perf_lookups);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_mis = 32'd0;
        test_reset();
        test_counter();
        test_alias();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_perf_sat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
